// File: rtl/volume_meter_gen.sv
// Volume meter: tracks the peak mic sample over each refresh window,
// quantises it against BASE + (k-1)*STEP thresholds one level per cycle,
// keeps a decaying peak-hold marker and drives an LED bar in one of four
// fill orders.
//
// Ports:
//   CLK, RESETn    clock, synchronous active-low reset
//   sample_valid   strobe qualifying sample
//   sample         filtered mic sample (unsigned, SAMPLE_W bits)
//   tick           refresh strobe; closes the window and starts quantising
//   mode           fill order: 00 LSB-first, 10 MSB-first, 01 centre-out,
//                  11 edges-in
//   led            LED bar pattern
//   level, peak    current level and held peak (0..N_LED)
//   trigger        toggles once per window whose max exceeds TRIG_LVL
//   clip           one-cycle pulse alongside each trigger toggle
//   update         one-cycle pulse when led/level/peak are refreshed
module volume_meter_gen #(
  parameter int unsigned SAMPLE_W   = 12,
  parameter int unsigned N_LED      = 12,
  parameter int unsigned NUM_W      = 4,
  parameter int unsigned BASE       = 2150,
  parameter int unsigned STEP       = 100,
  parameter int unsigned TRIG_LVL   = 3600,
  parameter int unsigned HOLD_TICKS = 10
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                tick,
  input  logic [1:0]          mode,
  output logic [N_LED-1:0]    led,
  output logic [NUM_W-1:0]    level,
  output logic [NUM_W-1:0]    peak,
  output logic                trigger,
  output logic                clip,
  output logic                update
);

  localparam int unsigned TW     = SAMPLE_W + NUM_W + 8;
  localparam int unsigned HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [N_LED-1:0] LED_ONE = N_LED'(1);

  typedef enum logic [1:0] {IDLE, QUANT, UPDATE} state_t;

  state_t              state;
  logic [SAMPLE_W-1:0] win_max;
  logic [SAMPLE_W-1:0] m;
  logic [SAMPLE_W-1:0] s_in;
  logic [NUM_W-1:0]    k;
  logic [NUM_W-1:0]    cnt;
  logic [NUM_W-1:0]    peak_nxt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [HOLD_W-1:0]   hold_nxt;
  logic [TW-1:0]       thresh;
  logic [N_LED-1:0]    led_nxt;
  logic                accept;
  logic                hit;
  logic                trig_hit;

  // Bit index lit at 0-based position p of the fill order for mode md.
  function automatic int unsigned order_bit(input logic [1:0] md, input int unsigned p);
    int unsigned b;
    case (md)
      2'b00:   b = p;
      2'b10:   b = N_LED - 1 - p;
      2'b01:   b = p[0] ? (N_LED / 2 - 1 - p / 2) : (N_LED / 2 + p / 2);
      default: b = p[0] ? (p / 2) : (N_LED - 1 - p / 2);
    endcase
    return b;
  endfunction

  // Window snapshot, threshold compare and trigger detection.
  always_comb begin
    s_in     = sample_valid ? sample : '0;
    accept   = (state == IDLE) && tick;
    thresh   = TW'(BASE) + TW'(STEP) * (TW'(k) - TW'(1));
    hit      = TW'(m) > thresh;
    trig_hit = TW'(m) > TW'(TRIG_LVL);
  end

  // Peak-hold with decay; cnt is the freshly quantised level.
  always_comb begin
    peak_nxt = peak;
    hold_nxt = hold_cnt;
    if (cnt >= peak) begin
      peak_nxt = cnt;
      hold_nxt = HOLD_W'(HOLD_TICKS);
    end else if (hold_cnt != '0) begin
      hold_nxt = hold_cnt - HOLD_W'(1);
    end else begin
      peak_nxt = ((peak - NUM_W'(1)) > cnt) ? (peak - NUM_W'(1)) : cnt;
    end
  end

  // LED pattern: first cnt positions of the order, plus the peak marker.
  always_comb begin
    led_nxt = '0;
    for (int unsigned p = 0; p < N_LED; p++) begin
      if (p < 32'(cnt)) led_nxt = led_nxt | (LED_ONE << order_bit(mode, p));
    end
    if (peak_nxt > cnt) led_nxt = led_nxt | (LED_ONE << order_bit(mode, 32'(peak_nxt) - 1));
  end

  // Window capture, quantiser FSM and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state    <= IDLE;
      win_max  <= '0;
      m        <= '0;
      k        <= '0;
      cnt      <= '0;
      hold_cnt <= '0;
      led      <= '0;
      level    <= '0;
      peak     <= '0;
      trigger  <= 1'b0;
      clip     <= 1'b0;
      update   <= 1'b0;
    end else begin
      // A sample in the tick cycle belongs to the window being closed.
      if (accept) begin
        m       <= (s_in > win_max) ? s_in : win_max;
        win_max <= '0;
      end else if (sample_valid && (sample > win_max)) begin
        win_max <= sample;
      end

      clip   <= 1'b0;
      update <= 1'b0;

      case (state)
        IDLE: begin
          if (tick) begin
            state <= QUANT;
            k     <= NUM_W'(1);
            cnt   <= '0;
          end
        end
        QUANT: begin
          if (hit) cnt <= cnt + NUM_W'(1);
          if (k == NUM_W'(N_LED)) state <= UPDATE;
          else                    k     <= k + NUM_W'(1);
        end
        UPDATE: begin
          level    <= cnt;
          peak     <= peak_nxt;
          hold_cnt <= hold_nxt;
          led      <= led_nxt;
          update   <= 1'b1;
          if (trig_hit) begin
            trigger <= ~trigger;
            clip    <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_volume_meter_gen.sv
// Randomised bench for volume_meter_gen against a window-level reference
// model: per accepted tick it counts exceeded thresholds, applies the
// peak-hold rules and builds the LED order as explicit position lists.
module tb_volume_meter_gen;

  localparam int SAMPLE_W   = 12;
  localparam int N_LED      = 12;
  localparam int NUM_W      = 4;
  localparam int BASE       = 2150;
  localparam int STEP       = 100;
  localparam int TRIG_LVL   = 3600;
  localparam int HOLD_TICKS = 10;

  logic                CLK;
  logic                rst_n;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample;
  logic                tick;
  logic [1:0]          mode;
  logic [N_LED-1:0]    led;
  logic [NUM_W-1:0]    level;
  logic [NUM_W-1:0]    peak;
  logic                trigger;
  logic                clip;
  logic                update;

  volume_meter_gen #(
    .SAMPLE_W(SAMPLE_W), .N_LED(N_LED), .NUM_W(NUM_W), .BASE(BASE),
    .STEP(STEP), .TRIG_LVL(TRIG_LVL), .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .CLK(CLK), .RESETn(rst_n), .sample_valid(sample_valid), .sample(sample),
    .tick(tick), .mode(mode), .led(led), .level(level), .peak(peak),
    .trigger(trigger), .clip(clip), .update(update)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int win    = 0;
  int m_win  = 0;
  int busy   = 0;
  int pend   = 0;
  int hold   = 0;
  int e_led  = 0;
  int e_lvl  = 0;
  int e_pk   = 0;
  int e_trig = 0;
  int e_clip = 0;
  int e_upd  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int exp_led(input int md, input int lvl, input int pk);
    int ord[N_LED];
    int hi, lo, res;
    for (int i = 0; i < N_LED; i++) begin
      case (md)
        0: ord[i] = i;
        2: ord[i] = N_LED - 1 - i;
        default: ;
      endcase
    end
    if (md == 1) begin
      hi = N_LED / 2; lo = N_LED / 2 - 1;
      for (int i = 0; i < N_LED; i++) begin
        if (i % 2 == 0) begin ord[i] = hi; hi++; end
        else            begin ord[i] = lo; lo--; end
      end
    end else if (md == 3) begin
      hi = N_LED - 1; lo = 0;
      for (int i = 0; i < N_LED; i++) begin
        if (i % 2 == 0) begin ord[i] = hi; hi--; end
        else            begin ord[i] = lo; lo++; end
      end
    end
    res = 0;
    for (int i = 0; i < lvl; i++) res |= (1 << ord[i]);
    if (pk > lvl) res |= (1 << ord[pk - 1]);
    return res;
  endfunction

  function automatic int quantise(input int mv);
    int n = 0;
    for (int kk = 1; kk <= N_LED; kk++) if (mv > BASE + (kk - 1) * STEP) n++;
    return n;
  endfunction

  // Advance the model by one clock edge with the inputs the DUT just saw.
  task automatic model_edge(input logic r, input logic sv, input int s, input logic tk, input int md);
    bit apply_now;
    bit acc;
    int sv_val;
    apply_now = 0;
    acc = 0;
    if (!r) begin
      win = 0; m_win = 0; busy = 0; pend = 0; hold = 0;
      e_led = 0; e_lvl = 0; e_pk = 0; e_trig = 0; e_clip = 0; e_upd = 0;
      return;
    end
    e_upd = 0;
    e_clip = 0;
    if (busy > 0) begin
      busy--;
      if (busy == 0) apply_now = 1;
    end else if (tk) begin
      acc = 1;
    end
    if (acc) begin
      sv_val = sv ? s : 0;
      m_win  = (sv_val > win) ? sv_val : win;
      win    = 0;
      pend   = quantise(m_win);
      busy   = N_LED + 1;
    end else if (sv && s > win) begin
      win = s;
    end
    if (apply_now) begin
      e_lvl = pend;
      if (pend >= e_pk) begin
        e_pk = pend; hold = HOLD_TICKS;
      end else if (hold > 0) begin
        hold--;
      end else begin
        e_pk = (e_pk - 1 > pend) ? e_pk - 1 : pend;
      end
      e_led = exp_led(md, e_lvl, e_pk);
      e_upd = 1;
      if (m_win > TRIG_LVL) begin
        e_trig ^= 1;
        e_clip = 1;
      end
    end
  endtask

  task automatic step(input logic r, input logic sv, input int s, input logic tk, input int md);
    rst_n = r; sample_valid = sv; sample = SAMPLE_W'(s); tick = tk; mode = 2'(md);
    @(posedge CLK);
    model_edge(r, sv, s, tk, md);
    #1;
    check("level",   32'(level),   32'(e_lvl));
    check("peak",    32'(peak),    32'(e_pk));
    check("led",     32'(led),     32'(e_led));
    check("trigger", 32'(trigger), 32'(e_trig));
    check("clip",    32'(clip),    32'(e_clip));
    check("update",  32'(update),  32'(e_upd));
  endtask

  // Two optional samples, a tick (optionally with a sample), then idle.
  task automatic win3(input int a, input int b, input int c, input int md);
    if (a >= 0) step(1, 1, a, 0, md);
    if (b >= 0) step(1, 1, b, 0, md);
    step(1, c >= 0, (c >= 0) ? c : 0, 1, md);
    repeat (15) step(1, 0, 0, 0, md);
  endtask

  initial begin
    int lo, hi, md, s, sel;
    logic rr, sv, tk;
    rst_n = 1'b0; sample_valid = 1'b0; sample = '0; tick = 1'b0; mode = 2'b00;

    repeat (3) step(0, 0, 0, 0, 0);
    // Threshold boundary and basic fill modes
    win3(2150, -1, -1, 0);
    win3(2151, -1, -1, 0);
    win3(2000, 2400, 2655, 0);
    win3(2000, 2400, 2655, 2);
    win3(2400, -1, -1, 1);
    win3(2400, -1, -1, 3);
    repeat (6) step(1, 0, 0, 0, 0);
    win3(2400, -1, -1, 0);
    // Peak hold, decay and reload
    win3(2851, -1, -1, 0);
    repeat (14) win3(-1, -1, -1, 0);
    win3(3000, -1, -1, 0);
    repeat (13) win3(-1, -1, -1, 0);
    // Clip / trigger
    win3(4095, -1, -1, 0);
    win3(4095, -1, -1, 0);
    win3(3600, -1, -1, 0);
    win3(3601, -1, -1, 0);
    // Tick during QUANT ignored; window keeps accumulating
    step(1, 1, 2300, 1, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    step(1, 1, 2700, 1, 0);
    repeat (12) step(1, 0, 0, 0, 0);
    win3(-1, -1, -1, 0);
    // Reset during QUANT aborts the update
    step(1, 1, 3700, 1, 0);
    repeat (5) step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (20) step(1, 0, 0, 0, 0);

    // Randomised windows
    md = 0; lo = 1500; hi = 3000;
    for (int i = 0; i < 6000; i++) begin
      rr = ($urandom_range(0, 2999) != 0);
      sv = 1'($urandom_range(0, 1));
      s  = int'($urandom_range(lo, hi));
      if (lo > 0 && $urandom_range(0, 7) == 0) begin
        sel = int'($urandom_range(0, 13));
        s = (sel == 13) ? TRIG_LVL : (sel == 12) ? 4095 : BASE + STEP * sel;
      end
      tk = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 39) == 0) md = int'($urandom_range(0, 3));
      step(rr, sv, s, tk, md);
      if (tk) begin
        if ($urandom_range(0, 2) == 0) begin
          lo = 0; hi = 2100;
        end else begin
          lo = int'($urandom_range(1500, 3500));
          hi = lo + int'($urandom_range(0, 595));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
